// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache for the Fetch stage.
// IDLE answers same-cycle lookups. A miss runs an in-order multi-beat line
// fill from backing memory (FILL), then writes the tag and valid bit (INSTALL).
module icache_responder #(
    parameter int unsigned SIZE  = 32,
    parameter int unsigned LINES = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] pc,
    input  logic            pc_valid,
    input  logic            flush,
    output logic [SIZE-1:0] instruction,
    output logic            hit,
    output logic            mem_req,
    output logic [SIZE-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [SIZE-1:0] mem_rdata
);

    localparam int unsigned OFF_W  = 2;
    localparam int unsigned WSEL_W = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = SIZE - IDX_W - WSEL_W - OFF_W;

    localparam int unsigned WSEL_LO = OFF_W;
    localparam int unsigned IDX_LO  = OFF_W + WSEL_W;
    localparam int unsigned TAG_LO  = OFF_W + WSEL_W + IDX_W;

    localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        INSTALL = 2'd2
    } state_t;

    // Control state
    state_t              state_q,    state_d;
    logic [LINES-1:0]    valid_q,    valid_d;
    logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
    logic [WSEL_W-1:0]   beat_q,     beat_d;
    logic                flushed_q,  flushed_d;
    logic                mem_req_q,  mem_req_d;

    // Storage arrays (not reset)
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [TAG_W-1:0]    tag_d  [LINES];
    logic [SIZE-1:0]     data_q [LINES][WORDS];
    logic [SIZE-1:0]     data_d [LINES][WORDS];

    // PC field split
    logic [WSEL_W-1:0]   pc_word;
    logic [IDX_W-1:0]    pc_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic                unused_pc_offset;

    assign pc_word          = pc[IDX_LO-1:WSEL_LO];
    assign pc_idx           = pc[TAG_LO-1:IDX_LO];
    assign pc_tag           = pc[SIZE-1:TAG_LO];
    assign unused_pc_offset = ^pc[OFF_W-1:0];

    // Same-cycle lookup; only IDLE may hit, and a flush cycle never hits
    logic lookup_hit;

    always_comb begin
        lookup_hit = (state_q == IDLE) && pc_valid && !flush
                     && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    end

    assign hit         = lookup_hit;
    assign instruction = lookup_hit ? data_q[pc_idx][pc_word] : '0;
    assign mem_req     = mem_req_q;
    assign mem_addr    = {fill_tag_q, fill_idx_q, beat_q, 2'b00};

    // Next-state and fill/install control
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        beat_d     = beat_q;
        flushed_d  = flushed_q;
        mem_req_d  = 1'b0;
        tag_d      = tag_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                if (flush) begin
                    valid_d = '0;
                end
                if (pc_valid && !lookup_hit) begin
                    // Evict immediately so a partially refilled line is never hit
                    fill_tag_d      = pc_tag;
                    fill_idx_d      = pc_idx;
                    beat_d          = '0;
                    valid_d[pc_idx] = 1'b0;
                    state_d         = FILL;
                    mem_req_d       = 1'b1;
                end
            end

            FILL: begin
                mem_req_d = 1'b1;
                if (flush) begin
                    valid_d   = '0;
                    flushed_d = 1'b1;
                end
                if (mem_ready) begin
                    data_d[fill_idx_q][beat_q] = mem_rdata;
                    beat_d                     = beat_q + WSEL_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d   = INSTALL;
                        mem_req_d = 1'b0;
                    end
                end
            end

            INSTALL: begin
                if (flush) begin
                    valid_d = '0;
                end else if (!flushed_q) begin
                    tag_d[fill_idx_q]   = fill_tag_q;
                    valid_d[fill_idx_q] = 1'b1;
                end
                flushed_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            beat_q     <= '0;
            flushed_q  <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            beat_q     <= beat_d;
            flushed_q  <= flushed_d;
            mem_req_q  <= mem_req_d;
        end
    end

    // Tag and data arrays; contents survive reset, validity is tracked separately
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios followed by
// random traffic, compared against a line-level cache model.
module tb_icache_responder;

    localparam int unsigned SIZE  = 32;
    localparam int unsigned LINES = 8;
    localparam int unsigned WORDS = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [SIZE-1:0] pc = '0;
    logic            pc_valid = 1'b0;
    logic            flush = 1'b0;
    logic [SIZE-1:0] instruction;
    logic            hit;
    logic            mem_req;
    logic [SIZE-1:0] mem_addr;
    logic            mem_ready = 1'b0;
    logic [SIZE-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    icache_responder #(.SIZE(SIZE), .LINES(LINES), .WORDS(WORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .flush       (flush),
        .instruction (instruction),
        .hit         (hit),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    // Backing memory image covering byte addresses 0x000..0x3FF
    logic [31:0] mem_img [0:255];

    // Reference model: which line lives at each index, plus fill progress
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    int          m_mode;      // 0 = serving, 1 = fetching a line, 2 = committing the line
    int unsigned m_line;      // line number (byte address / 16) being fetched
    int unsigned m_beats;     // words already received for that line
    bit          m_poison;    // a flush hit the in-flight line

    logic        obs_hit;
    logic [31:0] obs_instr;
    logic        obs_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model
    task automatic cycle(input bit v, input logic [31:0] p, input bit f,
                         input bit rdy, input bit r, input bit en);
        logic [31:0] eaddr;
        logic [31:0] einstr;
        bit          ehit;
        bit          ereq;
        int unsigned idx;
        int unsigned tg;
        int unsigned fidx;
        @(negedge clk);
        eaddr     = 32'(m_line * 16 + m_beats * 4);
        pc        = p;
        pc_valid  = v;
        flush     = f;
        mem_ready = rdy;
        rst       = r;
        mem_rdata = (m_mode == 1) ? mem_img[eaddr[9:2]] : $urandom;
        #1;
        idx    = (p >> 4) % LINES;
        tg     = p >> 7;
        ehit   = (m_mode == 0) && v && !f && m_valid[idx] && (m_tag[idx] == tg);
        einstr = ehit ? mem_img[p[9:2]] : 32'h0;
        ereq   = (m_mode == 1);
        obs_hit   = hit;
        obs_instr = instruction;
        obs_req   = mem_req;
        if (en) begin
            chk("hit", 32'(hit), 32'(ehit));
            chk("instruction", instruction, einstr);
            chk("mem_req", 32'(mem_req), 32'(ereq));
            if (ereq) chk("mem_addr", mem_addr, eaddr);
        end
        fidx = m_line % LINES;
        if (r) begin
            model_clear_all();
            m_mode = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (f) model_clear_all();
                    if (v && !ehit) begin
                        m_mode       = 1;
                        m_line       = p >> 4;
                        m_beats      = 0;
                        m_poison     = 1'b0;
                        m_valid[idx] = 1'b0;
                    end
                end
                1: begin
                    if (f) begin
                        model_clear_all();
                        m_poison = 1'b1;
                    end
                    if (rdy) begin
                        m_beats++;
                        if (m_beats == WORDS) m_mode = 2;
                    end
                end
                default: begin
                    if (f) model_clear_all();
                    else if (!m_poison) begin
                        m_valid[fidx] = 1'b1;
                        m_tag[fidx]   = m_line / LINES;
                    end
                    m_mode = 0;
                end
            endcase
        end
    endtask

    // Keep requesting p with ready every cycle until a hit; lat = cycles before the hit
    task automatic run_until_hit(input logic [31:0] p, output int lat);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, p, 1'b0, 1'b1, 1'b0, 1'b1);
            if (obs_hit === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("hit_timeout", 32'(obs_hit), 32'd1);
    endtask

    initial begin
        int lat;
        int cnt;
        int mode_before;
        bit rdy;

        for (int i = 0; i < 256; i++) mem_img[i] = $urandom;
        mem_img[4] = 32'hA0;
        mem_img[5] = 32'hA1;
        mem_img[6] = 32'hA2;
        mem_img[7] = 32'hA3;
        model_clear_all();
        for (int i = 0; i < int'(LINES); i++) m_tag[i] = 0;
        m_mode = 0; m_line = 0; m_beats = 0; m_poison = 1'b0;

        // Reset and idle state
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_hit", 32'(obs_hit), 32'd0);
        chk("reset_instruction", obs_instr, 32'd0);
        chk("reset_mem_req", 32'(obs_req), 32'd0);

        // Cold miss at 0x10, four ready beats; pc wanders during the fill
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cold_miss_hit", 32'(obs_hit), 32'd0);
        cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h254, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h254, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("install_cycle_hit", 32'(obs_hit), 32'd0);
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("first_hit", 32'(obs_hit), 32'd1);
        chk("first_hit_instr", obs_instr, 32'hA0);

        // Same line, last word
        cycle(1'b1, 32'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("word3_instr", obs_instr, 32'hA3);
        chk("word3_mem_req", 32'(obs_req), 32'd0);

        // Conflict: 0x90 evicts 0x10, then 0x10 evicts 0x90
        run_until_hit(32'h90, lat);
        chk("conflict_fill_latency", 32'(lat), 32'd6);
        run_until_hit(32'h10, lat);
        chk("evicted_refill_latency", 32'(lat), 32'd6);

        // Each beat stalled five cycles
        cnt = 0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            mode_before = m_mode;
            rdy = (mode_before == 1) && (cnt == 5);
            cycle(1'b1, 32'h1A4, 1'b0, rdy, 1'b0, 1'b1);
            if (mode_before == 1) cnt = (cnt == 5) ? 0 : cnt + 1;
            if (obs_hit === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("stalled_miss_latency", 32'(lat), 32'd26);

        // Flush during the fill: line completes but stays invalid
        cycle(1'b1, 32'h2C8, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h2C8, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h2C8, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h2C8, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h2C8, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h2C8, 1'b0, 1'b0, 1'b0, 1'b1);
        run_until_hit(32'h2C8, lat);
        chk("flushed_line_refetch", 32'(lat), 32'd6);

        // Reset during beat 2 of a fill
        run_until_hit(32'h10, lat);
        run_until_hit(32'h1A4, lat);
        cycle(1'b1, 32'h3E0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h3E0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h3E0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h3E0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 32'h3E0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_abort_mem_req", 32'(obs_req), 32'd0);
        chk("rst_abort_hit", 32'(obs_hit), 32'd0);
        run_until_hit(32'h10, lat);
        chk("after_rst_line_10_misses", 32'(lat), 32'd6);
        run_until_hit(32'h1A4, lat);
        chk("after_rst_line_1a4_misses", 32'(lat), 32'd6);

        // Random traffic over four tags
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 9) < 8),
                  32'(($urandom_range(0, 3) << 7) | $urandom_range(0, 127)),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 199) == 0),
                  1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
